// File: rtl/sie_tx_sequencer.sv
// sie_tx_sequencer
//   Serialises USB token and data packets for a downstream bit stuffer.
//   A packet is SYNC (8 bits), PID (4 bits + complement), then either the
//   token address/endpoint fields followed by CRC5, or the data payload
//   followed by CRC16. All fields are sent LSB first. CRCs are sent inverted,
//   MSB first. A one-cycle EOP state closes every packet.
//
// Ports
//   clk, rst                : clock, asynchronous active-low reset
//   tok_req/pid/addr/endp   : token request and its fields (sampled in IDLE)
//   dat_req/pid/zlp         : data request, PID, zero-length flag
//   byte_data/valid/last    : payload byte source
//   byte_ready              : payload byte accepted this cycle
//   stuff_ready             : bit stuffer accepts bit_out this cycle
//   bit_out, bit_valid      : serial bit stream (held while stuff_ready=0)
//   token_pkt, data_pkt     : one-cycle grant pulses (on the IDLE cycle)
//   crc_phase               : CRC bits are being presented
//   eop                     : one-cycle pulse after the last CRC bit
//   busy                    : high in every state except IDLE
module sie_tx_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_req,
  input  logic [3:0] tok_pid,
  input  logic [6:0] tok_addr,
  input  logic [3:0] tok_endp,
  input  logic       dat_req,
  input  logic [3:0] dat_pid,
  input  logic       dat_zlp,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  input  logic       stuff_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       token_pkt,
  output logic       data_pkt,
  output logic       crc_phase,
  output logic       eop,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, SYNC, PID, TOKF, DATA, CRC5, CRC16, EOP
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [3:0]  pid_reg, pid_next;
  logic [6:0]  addr_reg, addr_next;
  logic [3:0]  endp_reg, endp_next;
  logic        is_tok_reg, is_tok_next;
  logic        zlp_reg, zlp_next;
  logic [7:0]  byte_reg, byte_next;
  logic        last_reg, last_next;
  logic        have_byte_reg, have_byte_next;
  logic [4:0]  crc5_reg, crc5_next;
  logic [15:0] crc16_reg, crc16_next;

  // Bit i of these vectors is the i-th bit on the wire for that field.
  logic [7:0]  pid_bits;
  logic [10:0] tokf_bits;
  logic        tokf_bit;
  logic        data_bit;
  logic [4:0]  crc5_step;
  logic [15:0] crc16_step;

  assign pid_bits  = {~pid_reg, pid_reg};
  assign tokf_bits = {endp_reg, addr_reg};
  assign tokf_bit  = tokf_bits[cnt_reg];
  assign data_bit  = byte_reg[cnt_reg[2:0]];

  // Serial LFSR step: feedback is register MSB xor incoming bit.
  assign crc5_step  = {crc5_reg[3:0], 1'b0} ^
                      ((crc5_reg[4] ^ tokf_bit) ? 5'h05 : 5'h00);
  assign crc16_step = {crc16_reg[14:0], 1'b0} ^
                      ((crc16_reg[15] ^ data_bit) ? 16'h8005 : 16'h0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      pid_reg       <= '0;
      addr_reg      <= '0;
      endp_reg      <= '0;
      is_tok_reg    <= 1'b0;
      zlp_reg       <= 1'b0;
      byte_reg      <= '0;
      last_reg      <= 1'b0;
      have_byte_reg <= 1'b0;
      crc5_reg      <= 5'h1f;
      crc16_reg     <= 16'hffff;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pid_reg       <= pid_next;
      addr_reg      <= addr_next;
      endp_reg      <= endp_next;
      is_tok_reg    <= is_tok_next;
      zlp_reg       <= zlp_next;
      byte_reg      <= byte_next;
      last_reg      <= last_next;
      have_byte_reg <= have_byte_next;
      crc5_reg      <= crc5_next;
      crc16_reg     <= crc16_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pid_next       = pid_reg;
    addr_next      = addr_reg;
    endp_next      = endp_reg;
    is_tok_next    = is_tok_reg;
    zlp_next       = zlp_reg;
    byte_next      = byte_reg;
    last_next      = last_reg;
    have_byte_next = have_byte_reg;
    crc5_next      = crc5_reg;
    crc16_next     = crc16_reg;
    byte_ready     = 1'b0;
    bit_out        = 1'b0;
    bit_valid      = 1'b0;
    token_pkt      = 1'b0;
    data_pkt       = 1'b0;
    crc_phase      = 1'b0;
    eop            = 1'b0;
    busy           = (state_reg != IDLE);

    unique case (state_reg)
      IDLE: begin
        // The grant pulses are combinational from the requests, so they are
        // qualified with rst to keep every output low while reset is held.
        if (rst && (tok_req || dat_req)) begin
          state_next     = SYNC;
          cnt_next       = '0;
          crc5_next      = 5'h1f;
          crc16_next     = 16'hffff;
          have_byte_next = 1'b0;
          addr_next      = tok_addr;
          endp_next      = tok_endp;
          if (tok_req) begin
            token_pkt   = 1'b1;
            is_tok_next = 1'b1;
            pid_next    = tok_pid;
            zlp_next    = 1'b0;
          end else begin
            data_pkt    = 1'b1;
            is_tok_next = 1'b0;
            pid_next    = dat_pid;
            zlp_next    = dat_zlp;
          end
        end
      end

      SYNC: begin
        bit_valid = 1'b1;
        bit_out   = (cnt_reg == 4'd7);
        if (stuff_ready) begin
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg == 4'd7) begin
            cnt_next   = '0;
            state_next = PID;
          end
        end
      end

      PID: begin
        bit_valid = 1'b1;
        bit_out   = pid_bits[cnt_reg[2:0]];
        if (stuff_ready) begin
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg == 4'd7) begin
            cnt_next   = '0;
            state_next = is_tok_reg ? TOKF : (zlp_reg ? CRC16 : DATA);
          end
        end
      end

      TOKF: begin
        bit_valid = 1'b1;
        bit_out   = tokf_bit;
        if (stuff_ready) begin
          crc5_next = crc5_step;
          cnt_next  = cnt_reg + 4'd1;
          if (cnt_reg == 4'd10) begin
            cnt_next   = '0;
            state_next = CRC5;
          end
        end
      end

      DATA: begin
        if (have_byte_reg) begin
          bit_valid = 1'b1;
          bit_out   = data_bit;
          if (stuff_ready) begin
            crc16_next = crc16_step;
            cnt_next   = cnt_reg + 4'd1;
            if (cnt_reg == 4'd7) begin
              cnt_next = '0;
              if (last_reg) begin
                have_byte_next = 1'b0;
                state_next     = CRC16;
              end else if (byte_valid) begin
                // Refill on the 8th bit's transfer keeps the stream gapless.
                byte_ready = 1'b1;
                byte_next  = byte_data;
                last_next  = byte_last;
              end else begin
                have_byte_next = 1'b0;
              end
            end
          end
        end else if (byte_valid) begin
          byte_ready     = 1'b1;
          byte_next      = byte_data;
          last_next      = byte_last;
          have_byte_next = 1'b1;
          cnt_next       = '0;
        end
      end

      // CRC registers are shifted out MSB first; refilling with ones is
      // harmless because they are reloaded at the next grant.
      CRC5: begin
        bit_valid = 1'b1;
        crc_phase = 1'b1;
        bit_out   = ~crc5_reg[4];
        if (stuff_ready) begin
          crc5_next = {crc5_reg[3:0], 1'b1};
          cnt_next  = cnt_reg + 4'd1;
          if (cnt_reg == 4'd4) begin
            cnt_next   = '0;
            state_next = EOP;
          end
        end
      end

      CRC16: begin
        bit_valid = 1'b1;
        crc_phase = 1'b1;
        bit_out   = ~crc16_reg[15];
        if (stuff_ready) begin
          crc16_next = {crc16_reg[14:0], 1'b1};
          cnt_next   = cnt_reg + 4'd1;
          if (cnt_reg == 4'd15) begin
            cnt_next   = '0;
            state_next = EOP;
          end
        end
      end

      EOP: begin
        eop        = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
